// File: rtl/inst_mem_responder_if.sv
// Fetch-side request/response bundle for the instruction memory responder.
// The master drives the request fields; the slave returns completion, stall and data.
interface inst_mem_responder_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr, createdump,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump,
        output DataOut, Done, Stall, CacheHit, err
    );
endinterface

// File: rtl/inst_mem_responder.sv
// Direct-mapped 8-line instruction cache over a word array; hit 0 cycles, miss MISS_LAT, write 1.
// Backpressure: Stall holds the requester through miss fills and writes; requests are ignored while busy.
module inst_mem_responder #(
    parameter int MEM_WORDS = 256,
    parameter int MISS_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [14:0]   lat_word;
    logic [15:0]   lat_data;
    logic          accept;
    logic          fill_we;
    logic          wr_we;

    logic [7:0]    line_vld;
    logic [11:0]   line_tag [8];
    logic [15:0]   line_dat [8];
    logic [15:0]   mem [MEM_WORDS];

    logic [15:0]   dat_out;
    logic          done, stall, hit_out, err_out;

    wire [2:0]     req_idx  = bus.Addr[3:1];
    wire [11:0]    req_tag  = bus.Addr[15:4];
    wire [2:0]     lat_idx  = lat_word[2:0];
    wire [11:0]    lat_tag  = lat_word[14:3];
    wire [AW-1:0]  lat_midx = lat_word[AW-1:0];
    wire           req_err  = (bus.Rd & bus.Wr) | ((bus.Rd | bus.Wr) & bus.Addr[0]);
    wire           req_hit  = line_vld[req_idx] && (line_tag[req_idx] == req_tag);
    wire           unused_createdump = bus.createdump;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        fill_we   = 1'b0;
        wr_we     = 1'b0;
        dat_out   = 16'h0000;
        done      = 1'b0;
        stall     = 1'b0;
        hit_out   = 1'b0;
        err_out   = 1'b0;
        case (state)
            IDLE: begin
                if (req_err) begin
                    done    = 1'b1;
                    err_out = 1'b1;
                end else if (bus.Rd) begin
                    if (req_hit) begin
                        done    = 1'b1;
                        hit_out = 1'b1;
                        dat_out = line_dat[req_idx];
                    end else begin
                        stall     = 1'b1;
                        accept    = 1'b1;
                        cnt_nxt   = 4'(MISS_LAT - 1);
                        state_nxt = FILL;
                    end
                end else if (bus.Wr) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    state_nxt = WRITE;
                end
            end
            FILL: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    dat_out   = mem[lat_midx];
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WRITE: begin
                done      = 1'b1;
                wr_we     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A reset cycle suppresses every response, including a completing fill or write.
    assign bus.DataOut  = rst ? dat_out : 16'h0000;
    assign bus.Done     = rst & done;
    assign bus.Stall    = rst & stall;
    assign bus.CacheHit = rst & hit_out;
    assign bus.err      = rst & err_out;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            line_vld <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fill_we) line_vld[lat_idx] <= 1'b1;
        end
    end

    // Payload storage is not reset; every write is gated by rst so an aborted op leaves it untouched.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_word <= bus.Addr[15:1];
            lat_data <= bus.DataIn;
        end
        if (rst && fill_we) begin
            line_tag[lat_idx] <= lat_tag;
            line_dat[lat_idx] <= mem[lat_midx];
        end
        if (rst && wr_we) begin
            mem[lat_midx] <= lat_data;
            if (line_vld[lat_idx] && (line_tag[lat_idx] == lat_tag))
                line_dat[lat_idx] <= lat_data;
        end
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: expected responses are queued at issue and popped on Done.
module tb_inst_mem_responder;
    localparam int MEM_WORDS = 256;
    localparam int MISS_LAT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_responder_if bus ();

    inst_mem_responder #(.MEM_WORDS(MEM_WORDS), .MISS_LAT(MISS_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic        hit;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/DataOut"},  {16'h0, bus.DataOut}, 32'h0);
        chk({tag, "/Done"},     {31'h0, bus.Done},    32'h0);
        chk({tag, "/Stall"},    {31'h0, bus.Stall},   32'h0);
        chk({tag, "/CacheHit"}, {31'h0, bus.CacheHit}, 32'h0);
        chk({tag, "/err"},      {31'h0, bus.err},     32'h0);
    endtask

    // Called just after a rising edge; returns just after the edge that closes the Done cycle.
    task automatic issue(input string tag, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d, input int lat,
                         input logic [15:0] edata, input logic ehit, input logic eerr,
                         input logic cd);
        exp_t e;
        int   n;
        bit   got;
        bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
        e.lat = lat; e.data = edata; e.hit = ehit; e.err = eerr; e.chk_data = cd;
        sb.push_back(e);
        n = 0; got = 1'b0;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (bus.Done === 1'b1) got = 1'b1;
            else begin
                chk({tag, "/Stall"},    {31'h0, bus.Stall},    32'h1);
                chk({tag, "/HitLow"},   {31'h0, bus.CacheHit}, 32'h0);
                n++;
            end
        end
        e = sb.pop_front();
        vectors++;
        assert (got) else begin
            miscompares++;
            $error("FAIL %s/timeout: observed no Done in %0d cycles expected Done after %0d", tag, n, e.lat);
        end
        if (got) begin
            chk({tag, "/latency"}, n, e.lat);
            if (e.chk_data) chk({tag, "/DataOut"}, {16'h0, bus.DataOut}, {16'h0, e.data});
            chk({tag, "/CacheHit"}, {31'h0, bus.CacheHit}, {31'h0, e.hit});
            chk({tag, "/err"},      {31'h0, bus.err},      {31'h0, e.err});
            chk({tag, "/StallDone"}, {31'h0, bus.Stall},   32'h0);
        end
        @(posedge clk); #1;
        bus.Rd = 1'b0; bus.Wr = 1'b0;
    endtask

    task automatic do_reset();
        bus.Rd = 1'b0; bus.Wr = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    localparam logic [15:0] WRAP_ADDR = 16'(2 * MEM_WORDS);

    initial begin
        bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = 16'h0; bus.DataIn = 16'h0; bus.createdump = 1'b0;
        @(posedge clk); #1;
        do_reset();

        issue("pre0",  0, 1, 16'h0000, 16'h1234, 1, 16'h0, 0, 0, 0);
        issue("pre10", 0, 1, 16'h0010, 16'h5678, 1, 16'h0, 0, 0, 0);
        issue("pre2",  0, 1, 16'h0002, 16'h1111, 1, 16'h0, 0, 0, 0);
        issue("pre4",  0, 1, 16'h0004, 16'h4444, 1, 16'h0, 0, 0, 0);

        do_reset();
        @(negedge clk);
        chk_idle("reset");
        @(posedge clk); #1;

        issue("miss0",     1, 0, 16'h0000, 16'h0, MISS_LAT, 16'h1234, 0, 0, 1);
        issue("hit0",      1, 0, 16'h0000, 16'h0, 0,        16'h1234, 1, 0, 1);
        issue("conf10",    1, 0, 16'h0010, 16'h0, MISS_LAT, 16'h5678, 0, 0, 1);
        issue("conf0",     1, 0, 16'h0000, 16'h0, MISS_LAT, 16'h1234, 0, 0, 1);
        issue("wrap",      1, 0, WRAP_ADDR, 16'h0, MISS_LAT, 16'h1234, 0, 0, 1);
        issue("rewrap0",   1, 0, 16'h0000, 16'h0, MISS_LAT, 16'h1234, 0, 0, 1);

        issue("wt_wr",     0, 1, 16'h0000, 16'hBEEF, 1, 16'h0, 0, 0, 0);
        issue("wt_hit",    1, 0, 16'h0000, 16'h0, 0, 16'hBEEF, 1, 0, 1);
        issue("miss2",     1, 0, 16'h0002, 16'h0, MISS_LAT, 16'h1111, 0, 0, 1);
        issue("b2b_hit0",  1, 0, 16'h0000, 16'h0, 0, 16'hBEEF, 1, 0, 1);
        issue("b2b_hit2",  1, 0, 16'h0002, 16'h0, 0, 16'h1111, 1, 0, 1);

        bus.createdump = 1'b1;
        issue("err_odd",   1, 0, 16'h0003, 16'h0, 0, 16'h0000, 0, 1, 1);
        issue("err_rdwr",  1, 1, 16'h0002, 16'h7777, 0, 16'h0000, 0, 1, 1);
        issue("err_wodd",  0, 1, 16'h0001, 16'hDEAD, 0, 16'h0000, 0, 1, 1);
        bus.createdump = 1'b0;
        issue("post_err2", 1, 0, 16'h0002, 16'h0, 0, 16'h1111, 1, 0, 1);
        issue("post_err0", 1, 0, 16'h0000, 16'h0, 0, 16'hBEEF, 1, 0, 1);

        @(negedge clk);
        chk_idle("idle");
        @(posedge clk); #1;

        // Reset two cycles into a miss of 0x0010; the fill must be abandoned.
        bus.Rd = 1'b1; bus.Addr = 16'h0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_fill/Done", {31'h0, bus.Done}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        issue("refill10",  1, 0, 16'h0010, 16'h0, MISS_LAT, 16'h5678, 0, 0, 1);
        issue("rehit10",   1, 0, 16'h0010, 16'h0, 0, 16'h5678, 1, 0, 1);

        // Reset landing on the WRITE cycle must drop both the Done pulse and the array write.
        bus.Wr = 1'b1; bus.Addr = 16'h0004; bus.DataIn = 16'hAAAA;
        @(negedge clk);
        chk("rst_wr/accStall", {31'h0, bus.Stall}, 32'h1);
        @(posedge clk); #1;
        bus.Wr = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr/Done", {31'h0, bus.Done}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        issue("rst_wr/read4", 1, 0, 16'h0004, 16'h0, MISS_LAT, 16'h4444, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
